i2c_target: RTL
===============

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h50, giving the 7-bit target address it responds to.
REQ-002 The block SHALL have parameter FILTER_LEN, default 3, giving the number of consecutive clk cycles an input must be stable before its filtered value updates.
REQ-003 Port clk, input, 1 bit: system clock, at least 20x the SCL rate.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port scl_in, input, 1 bit: pad value of SCL from the open-drain buffer.
REQ-006 Port sda_in, input, 1 bit: pad value of SDA from the open-drain buffer.
REQ-007 Port sda_oe, output, 1 bit: 1 pulls SDA low; 0 releases SDA.
REQ-008 Port reg_addr, output, 8 bits: register pointer for the current access.
REQ-009 Port reg_wdata, output, 8 bits: write data, valid while reg_we=1.
REQ-010 Port reg_we, output, 1 bit: one-clk write strobe.
REQ-011 Port reg_re, output, 1 bit: one-clk read strobe.
REQ-012 Port reg_rdata, input, 8 bits: read data, valid the clk after reg_re.
REQ-013 Port busy, output, 1 bit: high from START to STOP.

Function
REQ-014 Inputs SHALL pass through a 2-FF synchronizer, then the FILTER_LEN stability filter; all decoding SHALL use filtered values.
REQ-015 START/repeated START SHALL be detected when filtered SDA falls while filtered SCL is high; STOP when filtered SDA rises while filtered SCL is high.
REQ-016 SDA SHALL be sampled on filtered SCL rising edges; sda_oe SHALL change only on filtered SCL falling edges, except on abort (REQ-024).
REQ-017 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state goes to ADDR (bit count cleared); STOP from any state goes to IDLE.
REQ-018 ADDR: shift 8 bits MSB first.
- On match with DEV_ADDR: go to ADDR_ACK and hold sda_oe=1 from the falling edge after bit 8 until the falling edge after bit 9.
- On mismatch: go to IGNORE with sda_oe=0 until the next START or STOP.
REQ-019 R/W=0 after the address ACK: the first byte SHALL load the pointer and be ACKed (PTR, PTR_ACK).
- Each later byte SHALL be ACKed and produce one reg_we pulse, with reg_addr=pointer and reg_wdata=byte, within 2 clk of the 8th SCL rise.
- The pointer SHALL then increment modulo 256 (255 wraps to 0).
REQ-020 R/W=1 after the address ACK: reg_re SHALL pulse one clk with reg_addr=pointer, and reg_rdata SHALL be captured the next clk.
- The captured byte SHALL be driven MSB first, with sda_oe = NOT bit, starting at the falling edge that ends the ACK slot.
REQ-021 RDATA_ACK: sda_oe=0 during the 9th bit.
- Controller ACK (SDA low at the 9th rise): pointer increments, reg_re pulses, next byte fetched.
- Controller NACK: IGNORE until STOP or START, no further reg_re.
REQ-022 The pointer SHALL persist across transactions, so a write of the pointer only, then repeated START and read, reads from that pointer.
REQ-023 A partial byte interrupted by START/STOP SHALL be discarded with no reg_we, and the pointer SHALL be unchanged.
REQ-024 On START or STOP detection, sda_oe SHALL go to 0 on the next clk.
REQ-025 A START and STOP detected in the same clk cannot occur; a START during ADDR_ACK or the data phase SHALL restart address reception.

Reset
REQ-026 While reset=1, the state SHALL be IDLE and the synchronizers and filters SHALL be preset to 1.
- Outputs during reset: sda_oe=0, reg_we=0, reg_re=0, busy=0, reg_addr=0, reg_wdata=0.
REQ-027 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously); after release, the block SHALL ignore bus activity until the next START.

Verification
REQ-028 Write sequence START, 0xA0, 0x10, 0x5A, 0xC3, STOP -> three ACKs; reg_we at addr 0x10 data 0x5A, then addr 0x11 data 0xC3; busy low after STOP.
REQ-029 START, 0xA0, 0x20, repeated START, 0xA1, controller ACK, NACK, STOP, with reg_rdata returning 0x3C then 0x81 -> bytes 0x3C and 0x81 on SDA; reg_re at addr 0x20 and 0x21; no third reg_re.
REQ-030 START, 0xB0 (wrong address) -> SDA never pulled low; no strobes; a later START with 0xA0 is ACKed.
REQ-031 Pointer 0xFF write of 0x11, 0x22 -> reg_we at addr 0xFF then 0x00.
REQ-032 STOP after 4 data bits, and reset asserted while driving a read 0 bit -> no reg_we and sda_oe=0 within 1 clk (async for reset); the next transaction is correct.
REQ-033 1-clk glitch on SCL during a data bit with FILTER_LEN=3 -> no extra bit sampled; received byte unchanged.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer: write = pointer byte then data bytes,
// read = stream from the pointer. Inputs are synchronized and glitch-filtered first.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  logic [1:0] w_pad;
  logic [1:0] w_filt;
  logic [1:0] w_filt_d;

  assign w_pad = {sda_in, scl_in};

  // Index 0 is SCL, index 1 is SDA; a level must persist FILTER_LEN clocks to pass.
  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    logic          r_meta;
    logic          r_sync;
    logic          r_filt;
    logic          r_filt_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_meta   <= 1'b1;
        r_sync   <= 1'b1;
        r_filt   <= 1'b1;
        r_filt_d <= 1'b1;
        r_cnt    <= '0;
      end else begin
        r_meta   <= w_pad[gi];
        r_sync   <= r_meta;
        r_filt_d <= r_filt;
        if (r_sync == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
          r_filt <= r_sync;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_filt[gi]   = r_filt;
    assign w_filt_d[gi] = r_filt_d;
  end

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic [2:0] r_bit;
  logic [1:0] r_ph;
  logic       r_rw;
  logic       r_re_pend;
  logic       r_re_d;

  assign w_scl_rise = w_filt[0] & ~w_filt_d[0];
  assign w_scl_fall = ~w_filt[0] & w_filt_d[0];
  assign w_start    = w_filt[0] & w_filt_d[0] & w_filt_d[1] & ~w_filt[1];
  assign w_stop     = w_filt[0] & w_filt_d[0] & ~w_filt_d[1] & w_filt[1];
  assign w_byte     = {r_shift[6:0], w_filt[1]};
  assign reg_addr   = r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_bit     <= '0;
      r_ph      <= '0;
      r_rw      <= 1'b0;
      r_re_pend <= 1'b0;
      r_re_d    <= 1'b0;
      sda_oe    <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= r_re_pend;
      r_re_pend <= 1'b0;
      r_re_d    <= reg_re;
      if (r_re_d) r_shift <= reg_rdata;
      if (reg_we) r_ptr <= r_ptr + 8'd1;

      if (w_start) begin
        r_state <= S_ADDR;
        r_bit   <= '0;
        r_ph    <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_ph <= 2'd0;
                if (r_state == S_ADDR) begin
                  r_rw    <= w_byte[0];
                  r_state <= (w_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                end else if (r_state == S_PTR) begin
                  r_ptr   <= w_byte;
                  r_state <= S_PTR_ACK;
                end else begin
                  reg_we    <= 1'b1;
                  reg_wdata <= w_byte;
                  r_state   <= S_WDATA_ACK;
                end
              end
            end
          end
          // Phase 0 waits for the fall that opens the ACK slot, phase 1 for the one closing it.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_rise && r_ph == 2'd1 && r_state == S_ADDR_ACK && r_rw) r_re_pend <= 1'b1;
            if (w_scl_fall) begin
              if (r_ph == 2'd0) begin
                sda_oe <= 1'b1;
                r_ph   <= 2'd1;
              end else begin
                r_ph  <= 2'd0;
                r_bit <= '0;
                if (r_state == S_ADDR_ACK && r_rw) begin
                  r_state <= S_RDATA;
                  sda_oe  <= ~r_shift[7];
                end else begin
                  sda_oe  <= 1'b0;
                  r_state <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (w_scl_fall) begin
              r_shift <= {r_shift[6:0], 1'b0};
              sda_oe  <= ~r_shift[6];
            end
            if (w_scl_rise) begin
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_state <= S_RDATA_ACK;
                r_ph    <= 2'd0;
              end
            end
          end
          S_RDATA_ACK: begin
            if (r_ph == 2'd0) begin
              if (w_scl_fall) begin
                sda_oe <= 1'b0;
                r_ph   <= 2'd1;
              end
            end else if (r_ph == 2'd1) begin
              if (w_scl_rise) begin
                if (!w_filt[1]) begin
                  r_ptr     <= r_ptr + 8'd1;
                  r_re_pend <= 1'b1;
                  r_ph      <= 2'd2;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end else if (w_scl_fall) begin
              r_state <= S_RDATA;
              r_bit   <= '0;
              sda_oe  <= ~r_shift[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
